imem_loader: RTL
================

Name: imem_loader

Overview:
- Instruction-memory writer that boots the single-cycle MIPS core. It accepts symbolic instructions (class plus fields) over a valid/ready stream and encodes them into 32-bit MIPS machine words.
- Encoding is the inverse of the core's opcode decode.
- Encoded words are written sequentially into instruction memory through a registered write port.
- While loading, the core is held idle; `cpu_run` releases it once loading completes.

Parameters:
- ADDR_W, 6, word-address width of instruction memory.
- DEPTH, 64, number of words the loader may write (must be ≤ 2^ADDR_W).
- BASE, 0, first word address written after start.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle pulse; begins a load session.
- finish  input  1  one-cycle pulse; ends the session early.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader can accept a beat.
- in_class  input  3  instruction class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6–7 illegal.
- in_rs  input  5  source register field.
- in_rt  input  5  target register field.
- in_rd  input  5  destination register field (R-type only).
- in_shamt  input  5  shift amount (R-type only).
- in_funct  input  6  function field (R-type only).
- in_imm  input  16  immediate/offset (lw, sw, beq, addi).
- in_target  input  26  jump target (j).
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  words written this session.
- err  output  1  sticky illegal-class flag.
- cpu_run  output  1  core release; high only in DONE.

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - state IDLE
  - imem_we 0, imem_addr BASE, imem_wdata 0
  - count 0, err 0, cpu_run 0, in_ready 0
- Reset has priority over all other inputs. Reset mid-session abandons it; the partially written memory is not cleared.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start. On entry, clears count and err and sets the write pointer to BASE.
  - LOAD -> DONE on finish, or when count reaches DEPTH after a write.
  - DONE -> LOAD on start, with the same clearing as IDLE -> LOAD.
  - start has no effect while in LOAD.
- in_ready = (state == LOAD) && (count < DEPTH). It is combinational from registered state only.
- A beat is accepted when in_valid && in_ready.
- Accepted legal beat, one-cycle latency:
  - next cycle imem_we = 1, imem_addr = pointer, imem_wdata = encoded word.
  - pointer and count increment by 1.
  - imem_we is 0 in every cycle without an accepted legal beat.
- Encoding (opcode in bits 31:26):
  - R: {000000, rs, rt, rd, shamt, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - addi: {001000, rs, rt, imm}
  - j: {000010, target}
  - Unused fields for a class are ignored.
- Illegal class (6, 7): the beat is still consumed and err is set (sticky until reset or next start). No write occurs and count is unchanged.
- Simultaneous finish and accepted beat: the beat is written, then the FSM enters DONE.
- Full: when the DEPTH-th word is written, in_ready drops the same cycle the count reaches DEPTH, and the FSM enters DONE. No address wrap ever occurs.
- cpu_run is registered and rises the cycle after DONE is entered.

Test Plan:
- Reset, start, then addi rs=0 rt=8 imm=5 -> next cycle imem_we=1, addr=0, wdata=0x20080005; count=1.
- Back-to-back beats with in_valid held, one per cycle:
  - R rs=8 rt=9 rd=10 shamt=0 funct=0x20 -> 0x01095020 at addr 0.
  - lw rs=8 rt=9 imm=4 -> 0x8D090004 at addr 1.
  - sw rs=0 rt=9 imm=8 -> 0xAC090008 at addr 2.
  - beq rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF at addr 3.
  - j target=0x10 -> 0x08000010 at addr 4.
  - Addresses are consecutive with no bubbles.
- Class 6 between two addi beats -> err=1, only 2 writes (addr 0, 1), count=2, in_ready stays high.
- DEPTH=4 with 6 beats offered -> 4 writes at addr 0–3, in_ready low after the 4th acceptance, DONE entered, cpu_run=1 the following cycle.
- finish asserted in the same cycle as a beat -> that word is written; the FSM goes to DONE; a later start clears count/err and the next write lands at BASE.
- rst_n low for one cycle mid-LOAD with in_valid high -> all outputs return to reset values, no write that cycle, in_ready=0 until the next start.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: encodes symbolic MIPS instructions from a valid/ready
// stream and writes them sequentially into instruction memory before releasing the core.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              cpu_run
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              legal;
    logic              begin_session;
    logic              last_word;
    logic [31:0]       enc_word;

    assign in_ready      = (state == LOAD) && (count < DEPTH_C);
    assign accept        = in_valid && in_ready;
    assign legal         = (in_class <= 3'd5);
    assign begin_session = start && ((state == IDLE) || (state == DONE));
    assign last_word     = accept && legal && ((count + COUNT_ONE) == DEPTH_C);

    // Inverse of the core's opcode decode; fields a class does not use are dropped.
    always_comb begin
        enc_word = 32'h0;
        case (in_class)
            3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            3'd4:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            3'd5:    enc_word = {6'b000010, in_target};
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (finish || last_word) next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // cpu_run follows DONE one cycle late and drops on the restart edge itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= BASE_C;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_C;
            imem_wdata <= 32'h0;
            count      <= '0;
            err        <= 1'b0;
            cpu_run    <= 1'b0;
        end else begin
            state   <= next_state;
            cpu_run <= (state == DONE) && (next_state == DONE);
            imem_we <= 1'b0;
            if (begin_session) begin
                count <= '0;
                err   <= 1'b0;
                ptr   <= BASE_C;
            end else if (accept) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc_word;
                    ptr        <= ptr + PTR_ONE;
                    count      <= count + COUNT_ONE;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
